// File: rtl/cache_mem_adapter_if.sv
// Word-beat memory port between the cache memory adapter (master) and main memory (slave).
interface cache_mem_adapter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
);
  logic              mm_req;
  logic              mm_we;
  logic [ADDR_W-1:0] mm_addr;
  logic [WORD_W-1:0] mm_wdata;
  logic              mm_ready;
  logic              mm_rvalid;
  logic [WORD_W-1:0] mm_rdata;

  modport master (
    output mm_req, mm_we, mm_addr, mm_wdata,
    input  mm_ready, mm_rvalid, mm_rdata
  );

  modport slave (
    input  mm_req, mm_we, mm_addr, mm_wdata,
    output mm_ready, mm_rvalid, mm_rdata
  );
endinterface

// File: rtl/cache_mem_adapter.sv
// Moves one cache line between the cache FSM and main memory as a sequence of word beats.
// Writebacks issue back-to-back write beats; fills issue one read at a time and wait for rvalid.
module cache_mem_adapter #(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned WORD_W     = 32,
  parameter  int unsigned LINE_WORDS = 4,
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS),
  localparam int unsigned OFF_W      = BEAT_W + $clog2(WORD_W / 8),
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_W-OFF_W-1:0] line_addr,
  input  logic [LINE_W-1:0]       wr_line,
  output logic [LINE_W-1:0]       rd_line,
  output logic                    ca_resp,
  output logic                    busy,
  output logic                    err,
  cache_mem_adapter_if.master     mem
);

  localparam int unsigned BYTE_OFF_W = OFF_W - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_REQ, RD_WAIT, RESP} state_e;

  state_e                             state_q, state_d;
  logic [BEAT_W-1:0]                  beat_q, beat_d;
  logic [ADDR_W-OFF_W-1:0]            line_q, line_d;
  logic [LINE_WORDS-1:0][WORD_W-1:0]  wbuf_q, wbuf_d;
  logic [LINE_WORDS-1:0][WORD_W-1:0]  rbuf_q, rbuf_d;
  logic                               err_q, err_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  // Next-state, beat sequencing and read-data capture
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          line_d  = line_addr;
          wbuf_d  = wr_line;
          beat_d  = '0;
          state_d = WR_BEAT;
          err_d   = mem_read;
        end else if (mem_read) begin
          line_d  = line_addr;
          beat_d  = '0;
          state_d = RD_REQ;
        end
      end
      WR_BEAT: begin
        err_d = mem_read | mem_write;
        if (mem.mm_ready) begin
          if (beat_q == LAST_BEAT) state_d = RESP;
          else                     beat_d  = beat_q + BEAT_W'(1);
        end
      end
      RD_REQ: begin
        err_d = mem_read | mem_write;
        if (mem.mm_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        err_d = mem_read | mem_write;
        if (mem.mm_rvalid) begin
          rbuf_d[beat_q] = mem.mm_rdata;
          if (beat_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = RD_REQ;
          end
        end
      end
      RESP: begin
        err_d   = mem_read | mem_write;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem.mm_req = 1'b0;
    mem.mm_we  = 1'b0;
    ca_resp    = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      WR_BEAT: begin
        mem.mm_req = 1'b1;
        mem.mm_we  = 1'b1;
      end
      RD_REQ:  mem.mm_req = 1'b1;
      RESP:    ca_resp    = 1'b1;
      default: ;
    endcase
  end

  assign mem.mm_addr  = ADDR_W'({line_q, beat_q}) << BYTE_OFF_W;
  assign mem.mm_wdata = wbuf_q[beat_q];
  assign rd_line      = rbuf_q;
  assign err          = err_q;

endmodule

// File: tb/tb_cache_mem_adapter.sv
// Directed bench for cache_mem_adapter: vector table for writebacks/illegal requests,
// hand-written sequences for stalled fills, back-to-back transfers and reset mid-fill.
module tb_cache_mem_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  line_addr;
  logic [127:0] wr_line;
  logic [127:0] rd_line;
  logic         ca_resp;
  logic         busy;
  logic         err;

  cache_mem_adapter_if #(.ADDR_W(32), .WORD_W(32)) mif ();

  cache_mem_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .line_addr (line_addr),
    .wr_line   (wr_line),
    .rd_line   (rd_line),
    .ca_resp   (ca_resp),
    .busy      (busy),
    .err       (err),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int resp_cnt = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ca_resp) resp_cnt <= resp_cnt + 1;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        rdy;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp;
    logic        bsy;
    logic        er;
  } vec_t;

  function automatic vec_t mkv(logic rd, logic wr, logic rdy, logic req, logic we,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic resp, logic bsy, logic er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rdy = rdy; v.req = req; v.we = we;
    v.addr = addr; v.wdata = wdata; v.resp = resp; v.bsy = bsy; v.er = er;
    return v;
  endfunction

  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic chk128(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read beat starting in the cycle where RD_REQ is visible
  task automatic read_beat(input int b, input logic [31:0] base, input logic [31:0] d,
                           input int stall, input int lat);
    logic [31:0] a;
    a = base + 32'(4 * b);
    chk1("rd_req", mif.mm_req, 1'b1);
    chk1("rd_we", mif.mm_we, 1'b0);
    chk32("rd_addr", mif.mm_addr, a);
    for (int s = 0; s < stall; s++) begin
      mif.mm_ready = 1'b0;
      tick();
      chk1("stall_req", mif.mm_req, 1'b1);
      chk32("stall_addr", mif.mm_addr, a);
    end
    mif.mm_ready = 1'b1;
    tick();
    chk1("wait_req", mif.mm_req, 1'b0);
    for (int k = 1; k < lat; k++) begin
      tick();
      chk1("wait_req_lat", mif.mm_req, 1'b0);
    end
    mif.mm_rvalid = 1'b1;
    mif.mm_rdata  = d;
    tick();
    mif.mm_rvalid = 1'b0;
    mif.mm_rdata  = 32'h0;
  endtask

  task automatic do_fill(input logic [27:0] la, input logic [127:0] words, input int stall_beat,
                         input int stall_n, input int lat, input int exp_cycles);
    int t0;
    int r0;
    r0 = resp_cnt;
    mem_read  = 1'b1;
    line_addr = la;
    t0 = cyc;
    tick();
    mem_read = 1'b0;
    chk1("fill_busy", busy, 1'b1);
    for (int b = 0; b < 4; b++)
      read_beat(b, {la, 4'b0}, words[b*32 +: 32], (b == stall_beat) ? stall_n : 0, lat);
    chk1("fill_resp", ca_resp, 1'b1);
    chk1("fill_busy_resp", busy, 1'b1);
    chk32("fill_resp_cycle", 32'(cyc - t0), 32'(exp_cycles));
    chk128("fill_rd_line", rd_line, words);
    tick();
    chk1("fill_resp_end", ca_resp, 1'b0);
    chk1("fill_busy_end", busy, 1'b0);
    chk32("fill_resp_pulses", 32'(resp_cnt - r0), 32'd1);
  endtask

  task automatic do_write(input logic [27:0] la, input logic [127:0] words,
                          input logic [127:0] exp_rd);
    int t0;
    mem_write = 1'b1;
    line_addr = la;
    wr_line   = words;
    t0 = cyc;
    tick();
    mem_write = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk1("wr_req", mif.mm_req, 1'b1);
      chk1("wr_we", mif.mm_we, 1'b1);
      chk32("wr_addr", mif.mm_addr, {la, 4'b0} + 32'(4 * b));
      chk32("wr_data", mif.mm_wdata, words[b*32 +: 32]);
      tick();
    end
    chk1("wr_resp", ca_resp, 1'b1);
    chk32("wr_resp_cycle", 32'(cyc - t0), 32'd5);
    chk128("wr_keeps_rd_line", rd_line, exp_rd);
    tick();
    chk1("wr_resp_end", ca_resp, 1'b0);
  endtask

  vec_t tbl [13];

  initial begin
    int r0;
    logic [127:0] fill1;
    logic [127:0] fill2;
    logic [127:0] fill3;

    // Writeback with ready high, then simultaneous rd+wr, then read during WR_BEAT with a stall
    tbl[0]  = mkv(0, 1, 1, 1, 1, 32'h400, 32'hA0, 0, 1, 0);
    tbl[1]  = mkv(0, 0, 1, 1, 1, 32'h404, 32'hA1, 0, 1, 0);
    tbl[2]  = mkv(0, 0, 1, 1, 1, 32'h408, 32'hA2, 0, 1, 0);
    tbl[3]  = mkv(0, 0, 1, 1, 1, 32'h40C, 32'hA3, 0, 1, 0);
    tbl[4]  = mkv(0, 0, 1, 0, 0, 32'h0,   32'h0,  1, 1, 0);
    tbl[5]  = mkv(0, 0, 1, 0, 0, 32'h0,   32'h0,  0, 0, 0);
    tbl[6]  = mkv(1, 1, 1, 1, 1, 32'h400, 32'hA0, 0, 1, 1);
    tbl[7]  = mkv(1, 0, 0, 1, 1, 32'h400, 32'hA0, 0, 1, 1);
    tbl[8]  = mkv(0, 0, 1, 1, 1, 32'h404, 32'hA1, 0, 1, 0);
    tbl[9]  = mkv(0, 0, 1, 1, 1, 32'h408, 32'hA2, 0, 1, 0);
    tbl[10] = mkv(0, 0, 1, 1, 1, 32'h40C, 32'hA3, 0, 1, 0);
    tbl[11] = mkv(0, 0, 1, 0, 0, 32'h0,   32'h0,  1, 1, 0);
    tbl[12] = mkv(0, 0, 1, 0, 0, 32'h0,   32'h0,  0, 0, 0);

    fill1 = {32'h44, 32'h33, 32'h22, 32'h11};
    fill2 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    fill3 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    rst           = 1'b1;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    line_addr     = '0;
    wr_line       = '0;
    mif.mm_ready  = 1'b1;
    mif.mm_rvalid = 1'b0;
    mif.mm_rdata  = 32'h0;
    repeat (3) tick();

    chk1("rst_req", mif.mm_req, 1'b0);
    chk1("rst_we", mif.mm_we, 1'b0);
    chk32("rst_addr", mif.mm_addr, 32'h0);
    chk32("rst_wdata", mif.mm_wdata, 32'h0);
    chk128("rst_rd_line", rd_line, 128'h0);
    chk1("rst_resp", ca_resp, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();
    chk1("idle_busy", busy, 1'b0);

    line_addr = 28'h40;
    wr_line   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    r0 = resp_cnt;
    for (int i = 0; i < 13; i++) begin
      mem_read     = tbl[i].rd;
      mem_write    = tbl[i].wr;
      mif.mm_ready = tbl[i].rdy;
      tick();
      chk1($sformatf("v%0d_req", i), mif.mm_req, tbl[i].req);
      chk1($sformatf("v%0d_we", i), mif.mm_we, tbl[i].we);
      if (tbl[i].req) begin
        chk32($sformatf("v%0d_addr", i), mif.mm_addr, tbl[i].addr);
        chk32($sformatf("v%0d_wdata", i), mif.mm_wdata, tbl[i].wdata);
      end
      chk1($sformatf("v%0d_resp", i), ca_resp, tbl[i].resp);
      chk1($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
      chk1($sformatf("v%0d_err", i), err, tbl[i].er);
      chk128($sformatf("v%0d_rd_line", i), rd_line, 128'h0);
    end
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mif.mm_ready = 1'b1;
    chk32("table_resp_pulses", 32'(resp_cnt - r0), 32'd2);

    // Fill: 2-cycle ready stall on beat 1, 3-cycle rvalid latency
    do_fill(28'h10, fill1, 1, 2, 3, 19);

    // Writeback then fill in the cycle right after ca_resp
    do_write(28'h20, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, fill1);
    do_fill(28'h30, fill2, -1, 0, 1, 9);

    // Reset while waiting for the third read beat
    r0 = resp_cnt;
    mem_read  = 1'b1;
    line_addr = 28'h50;
    tick();
    mem_read = 1'b0;
    read_beat(0, 32'h500, 32'hE0, 0, 1);
    read_beat(1, 32'h500, 32'hE1, 0, 1);
    chk32("abort_addr", mif.mm_addr, 32'h508);
    tick();
    chk1("abort_in_wait", mif.mm_req, 1'b0);
    chk1("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_req", mif.mm_req, 1'b0);
    chk128("abort_rd_line", rd_line, 128'h0);
    mif.mm_rvalid = 1'b1;
    mif.mm_rdata  = 32'hDEADBEEF;
    tick();
    mif.mm_rvalid = 1'b0;
    mif.mm_rdata  = 32'h0;
    chk1("late_rvalid_busy", busy, 1'b0);
    chk128("late_rvalid_rd_line", rd_line, 128'h0);
    chk1("late_rvalid_resp", ca_resp, 1'b0);
    tick();
    chk32("abort_no_resp", 32'(resp_cnt - r0), 32'd0);
    do_fill(28'h60, fill3, -1, 0, 1, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_adapter.md
# cache_mem_adapter

Memory-side adapter between the cache controller FSM and main memory. It takes the controller's single-cycle `mem_write` (line writeback) and `mem_read` (line fill) requests and moves one full cache line as a sequence of word beats on a simple request/ready/rvalid memory port. Completion is returned to the controller as a one-cycle `ca_resp` pulse; fill data is returned on `rd_line`. It sits directly downstream of the cache FSM.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `WORD_W`, 32, memory word width; multiple of 8.
- `LINE_WORDS`, 4, words per cache line; power of 2, ≥2.
- Derived: `BEAT_W = log2(LINE_WORDS)`; `OFF_W = BEAT_W + log2(WORD_W/8)`; `LINE_W = LINE_WORDS*WORD_W`.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, synchronous, active-high reset.
- `mem_read`, in, 1, line-fill request pulse from the cache FSM.
- `mem_write`, in, 1, line-writeback request pulse from the cache FSM.
- `line_addr`, in, `ADDR_W-OFF_W`, line address; sampled on acceptance.
- `wr_line`, in, `LINE_W`, line data to write back; sampled on acceptance.
- `rd_line`, out, `LINE_W`, filled line; word i is at `[i*WORD_W +: WORD_W]`.
- `ca_resp`, out, 1, one-cycle completion pulse.
- `busy`, out, 1, high from the cycle after acceptance through the `ca_resp` cycle.
- `err`, out, 1, one-cycle pulse for an illegal request.
- `mm_req`, out, 1, beat request valid.
- `mm_we`, out, 1, 1 = write beat, 0 = read beat.
- `mm_addr`, out, `ADDR_W`, word byte address: `{line, beat, OFF_W-BEAT_W zeros}`.
- `mm_wdata`, out, `WORD_W`, write beat data.
- `mm_ready`, in, 1, the beat is accepted when `mm_req && mm_ready`.
- `mm_rvalid`, in, 1, read data valid; in order, at most one outstanding read.
- `mm_rdata`, in, `WORD_W`, read data.

## Operation
States: IDLE, WR_BEAT, RD_REQ, RD_WAIT, RESP.

**IDLE**
- Requests are accepted only in IDLE.
- `mem_write`: latch `line_addr` and `wr_line`, clear `beat`, go to WR_BEAT.
- `mem_read` alone: latch `line_addr`, clear `beat`, go to RD_REQ.
- `mem_read` and `mem_write` together: the write is serviced, the read is dropped, and `err` pulses.
- `mm_rvalid` is ignored in IDLE.

**WR_BEAT**
- Drives `mm_req=1`, `mm_we=1`, `mm_wdata` = latched word[`beat`].
- On `mm_ready`: if `beat==LINE_WORDS-1`, go to RESP; otherwise `beat++`.

**RD_REQ**
- Drives `mm_req=1`, `mm_we=0`.
- On `mm_ready`, go to RD_WAIT.

**RD_WAIT**
- `mm_req=0`.
- On `mm_rvalid`: capture `mm_rdata` into `rd_line` word[`beat`]. If last beat, go to RESP; otherwise `beat++` and go to RD_REQ.

**RESP**
- `ca_resp=1` for exactly one cycle, then go to IDLE.

**Other rules**
- Any `mem_read` or `mem_write` while not in IDLE is ignored and pulses `err`; the current transfer is unaffected.
- `mm_addr` and `mm_wdata` must be held stable while `mm_req` is high and not yet accepted.
- `rd_line` changes only during read beats. It holds the previous value during writes and after completion, until the next read overwrites it beat by beat.
- `beat` wraps only by returning to IDLE; it never exceeds `LINE_WORDS-1`.
- Reset mid-transfer: go to IDLE and abort with no `ca_resp`. A late `mm_rvalid` from the aborted read is ignored because the block is in IDLE.
- Reset values: state IDLE; `ca_resp`, `busy`, `err`, `mm_req`, `mm_we` = 0; `mm_addr`, `mm_wdata`, `rd_line` = 0.

## Timing
- Request sampled at cycle 0; first `mm_req` at cycle 1.
- Write line, `mm_ready` tied high: beats in cycles 1..`LINE_WORDS`; `ca_resp` at `LINE_WORDS+1` (cycle 5 at the defaults).
- Read line, `mm_ready` high and `rvalid` one cycle after acceptance: 2 cycles per beat; `ca_resp` at `2*LINE_WORDS+1` (cycle 9 at the defaults).
- Each `mm_ready` stall cycle and each extra `rvalid` delay cycle adds exactly one cycle.
- `rd_line` is complete and valid in the `ca_resp` cycle.
- Earliest next acceptance is the cycle after `ca_resp`.
- All outputs are registered or decoded from registered state; there is no combinational path from `mm_ready` or `mm_rvalid` to outputs.

## Test plan
- **Writeback, no stalls:** `mem_write`, `line_addr=0x0000040`, `wr_line` words {A0,A1,A2,A3}, `mm_ready=1`. Expect beats to addresses 0x400, 0x404, 0x408, 0x40C with data A0..A3 in cycles 1–4, `ca_resp` in cycle 5, `busy` high in cycles 1–5.
- **Fill with stalls:** `mem_read`, `line_addr=0x10`; `mm_ready` low 2 cycles on beat 1; `rvalid` returns 11,22,33,44 with 3-cycle latency. Expect `rd_line={44,33,22,11}` (word3..word0), a single `ca_resp`, and `mm_addr` stable during the stall.
- **Back-to-back writeback then fill:** `mem_write`, then `mem_read` on the cycle after `ca_resp`. Expect both serviced and two `ca_resp` pulses; `rd_line` unchanged by the write.
- **Illegal requests:** simultaneous `mem_read`+`mem_write` → write only, `err`=1 for one cycle. `mem_read` during WR_BEAT → ignored, `err` pulse, write completes normally.
- **Reset mid-fill:** assert `rst` in RD_WAIT after 2 beats. Expect IDLE, `rd_line=0`, no `ca_resp`; a following `mm_rvalid` is ignored; a new `mem_read` completes correctly.
